// File: rtl/ram_init_sequencer.sv
// Zero-initialisation sequencer: sweeps one shared write port over NUM_CLIENTS RAMs
// during the reset window, honouring per-client backpressure and reporting busy/done/abort.
module ram_init_sequencer #(
    parameter int                    NUM_CLIENTS = 4,
    parameter int                    ENTRY_NUM   = 1024,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    localparam int                   AW          = $clog2(ENTRY_NUM),
    localparam int                   CW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   initReq,
    input  logic [NUM_CLIENTS-1:0] wrReady,
    output logic [NUM_CLIENTS-1:0] we,
    output logic [AW-1:0]          wrAddr,
    output logic [DATA_WIDTH-1:0]  wrData,
    output logic                   busy,
    output logic                   done,
    output logic                   abort
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR   = AW'(ENTRY_NUM - 1);
    localparam logic [CW-1:0] LAST_CLIENT = CW'(NUM_CLIENTS - 1);

    state_t                   state_r;
    state_t                   next_state_s;
    logic [CW-1:0]            client_r;
    logic [CW-1:0]            next_client_s;
    logic [AW-1:0]            addr_r;
    logic [AW-1:0]            next_addr_s;
    logic                     abort_r;
    logic                     next_abort_s;
    logic [NUM_CLIENTS-1:0]   client_dec_s;
    logic                     sel_ready_s;

    // One-hot decode of the current client and selection of its ready bit
    always_comb begin
        client_dec_s = '0;
        sel_ready_s  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_dec_s[i] = (client_r == CW'(i));
            sel_ready_s     = sel_ready_s | (client_dec_s[i] & wrReady[i]);
        end
    end

    // State, counter and abort-pulse registers; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            client_r <= '0;
            addr_r   <= '0;
            abort_r  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            client_r <= next_client_s;
            addr_r   <= next_addr_s;
            abort_r  <= next_abort_s;
        end
    end

    // Next-state logic; a dropped initReq outranks write-acceptance bookkeeping
    always_comb begin
        next_state_s  = state_r;
        next_client_s = client_r;
        next_addr_s   = addr_r;
        next_abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (initReq) begin
                    next_state_s  = ST_SWEEP;
                    next_client_s = '0;
                    next_addr_s   = '0;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (!initReq) begin
                    next_state_s  = ST_IDLE;
                    next_client_s = '0;
                    next_addr_s   = '0;
                    next_abort_s  = 1'b1;
                end else if (sel_ready_s) begin
                    if (addr_r != LAST_ADDR) begin
                        next_addr_s = addr_r + AW'(1);
                    end else if (client_r != LAST_CLIENT) begin
                        next_addr_s   = '0;
                        next_client_s = client_r + CW'(1);
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_SWEEP;
                end
            end
            ST_DONE: begin
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s  = ST_IDLE;
                next_client_s = '0;
                next_addr_s   = '0;
            end
        endcase
    end

    // Output decode straight from registered state (no extra pipeline stage)
    always_comb begin
        we     = '0;
        wrAddr = '0;
        if (state_r == ST_SWEEP) begin
            we     = client_dec_s;
            wrAddr = addr_r;
        end else begin
            we     = '0;
            wrAddr = '0;
        end
    end

    assign wrData = INIT_VALUE;
    assign busy   = (state_r == ST_SWEEP);
    assign done   = (state_r == ST_DONE);
    assign abort  = abort_r;

endmodule
